// File: rtl/instruction_fetch.sv
// ============================================================================
// Module   : instruction_fetch
// Purpose  : Fetch stage in front of a zero-latency instruction ROM. Holds the
//            PC, captures the ROM word into an IF/ID register with a
//            valid/ready handshake toward decode, follows branch redirects
//            from execute, and stops on the halt idiom (beq x0,x0,0) or on a
//            misaligned / out-of-range fetch or redirect.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            Address           - fetch address to ROM (equals PC register)
//            Instruction       - ROM read data for Address, same cycle
//            Ready             - decode accepts InstrOut this cycle
//            BranchTaken/Target- redirect request from execute
//            Valid, InstrOut, PCOut, PCPlus4Out - IF/ID register contents
//            Halted, Fault     - sticky stop indications
//            DeliverCount      - saturating count of Valid&&Ready handshakes
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned MEM_WORDS   = 1024,
   parameter bit          HALT_DETECT = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] Address,
   input  logic [31:0] Instruction,
   input  logic        Ready,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   output logic        Valid,
   output logic [31:0] InstrOut,
   output logic [31:0] PCOut,
   output logic [31:0] PCPlus4Out,
   output logic        Halted,
   output logic        Fault,
   output logic [31:0] DeliverCount
);

   localparam logic [31:0] c_MEM_WORDS = 32'(MEM_WORDS);
   localparam logic [31:0] c_NOP       = 32'h0000_0013;
   localparam logic [31:0] c_HALT_INSN = 32'h0000_0063;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   state_t      state_q,  state_d;
   logic [31:0] pc_q,     pc_d;
   logic        valid_q,  valid_d;
   logic [31:0] instr_q,  instr_d;
   logic [31:0] pcout_q,  pcout_d;
   logic [31:0] pcp4_q,   pcp4_d;
   logic        halted_q, halted_d;
   logic        fault_q,  fault_d;
   logic [31:0] count_q,  count_d;

   logic        w_accept;
   logic        w_handshake;
   logic        w_pc_oor;
   logic        w_target_bad;
   logic        w_halt_idiom;
   logic [31:0] w_pc_plus4;

   // Word-index range checks are done on zero-extended word indices so the
   // comparison is against the full ROM depth without truncation.
   assign w_pc_oor     = ({2'b00, pc_q[31:2]} >= c_MEM_WORDS);
   assign w_target_bad = (BranchTarget[1:0] != 2'b00) ||
                         ({2'b00, BranchTarget[31:2]} >= c_MEM_WORDS);
   assign w_halt_idiom = HALT_DETECT && (Instruction == c_HALT_INSN);
   assign w_accept     = !valid_q || Ready;
   assign w_handshake  = valid_q && Ready;
   assign w_pc_plus4   = pc_q + 32'd4;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_RUN;
         pc_q     <= RESET_PC;
         valid_q  <= 1'b0;
         instr_q  <= c_NOP;
         pcout_q  <= 32'h0;
         pcp4_q   <= 32'h0;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
         count_q  <= 32'h0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         valid_q  <= valid_d;
         instr_q  <= instr_d;
         pcout_q  <= pcout_d;
         pcp4_q   <= pcp4_d;
         halted_q <= halted_d;
         fault_q  <= fault_d;
         count_q  <= count_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      valid_d  = valid_q;
      instr_d  = instr_q;
      pcout_d  = pcout_q;
      pcp4_d   = pcp4_q;
      halted_d = halted_q;
      fault_d  = fault_q;
      count_d  = count_q;

      // Handshakes are counted in every state, including one that happens
      // in the same cycle as a redirect flush or as the halt delivery.
      if (w_handshake && (count_q != 32'hFFFF_FFFF)) begin
         count_d = count_q + 32'd1;
      end

      unique case (state_q)
         ST_RUN: begin
            if (BranchTaken) begin
               valid_d = 1'b0;
               if (w_target_bad) begin
                  state_d = ST_FAULT;
                  fault_d = 1'b1;
               end else begin
                  // The target is fetched next cycle, not this one.
                  pc_d = BranchTarget;
               end
            end else if (w_pc_oor) begin
               state_d = ST_FAULT;
               fault_d = 1'b1;
               valid_d = 1'b0;
            end else if (w_accept) begin
               instr_d = Instruction;
               pcout_d = pc_q;
               pcp4_d  = w_pc_plus4;
               valid_d = 1'b1;
               if (w_halt_idiom) begin
                  // PC stays on the halt instruction.
                  state_d  = ST_HALT;
                  halted_d = 1'b1;
               end else begin
                  pc_d = w_pc_plus4;
               end
            end
         end

         ST_HALT: begin
            // Only drain the halt instruction itself.
            if (w_handshake) begin
               valid_d = 1'b0;
            end
         end

         ST_FAULT: begin
            valid_d = 1'b0;
         end

         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   assign Address      = pc_q;
   assign Valid        = valid_q;
   assign InstrOut     = instr_q;
   assign PCOut        = pcout_q;
   assign PCPlus4Out   = pcp4_q;
   assign Halted       = halted_q;
   assign Fault        = fault_q;
   assign DeliverCount = count_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module   : tb_instruction_fetch
// Purpose  : Self-checking bench for instruction_fetch. A behavioural model
//            of the fetch rules tracks the expected IF/ID contents, PC and
//            counters; directed scenarios are followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_instruction_fetch;

   localparam int          MEM_WORDS = 1024;
   localparam logic [31:0] HALT_INSN = 32'h0000_0063;
   localparam int          M_RUN     = 0;
   localparam int          M_HALT    = 1;
   localparam int          M_FAULT   = 2;

   logic        clk          = 1'b0;
   logic        reset        = 1'b1;
   logic        Ready        = 1'b0;
   logic        BranchTaken  = 1'b0;
   logic [31:0] BranchTarget = 32'h0;
   logic [31:0] Address;
   logic [31:0] Instruction;
   logic        Valid;
   logic [31:0] InstrOut;
   logic [31:0] PCOut;
   logic [31:0] PCPlus4Out;
   logic        Halted;
   logic        Fault;
   logic [31:0] DeliverCount;

   logic [31:0] rom [0:MEM_WORDS-1];

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [31:0] m_pc     = 32'h0;
   logic        m_valid  = 1'b0;
   logic [31:0] m_instr  = 32'h13;
   logic [31:0] m_pcout  = 32'h0;
   logic [31:0] m_pcp4   = 32'h0;
   logic        m_halted = 1'b0;
   logic        m_fault  = 1'b0;
   logic [31:0] m_count  = 32'h0;
   int          m_mode   = M_RUN;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_rd(input logic [31:0] a);
      if (a[31:12] == 20'd0) return rom[a[11:2]];
      return 32'hDEAD_BEEF;
   endfunction

   assign Instruction = rom_rd(Address);

   instruction_fetch #(
      .RESET_PC    (32'h0000_0000),
      .MEM_WORDS   (MEM_WORDS),
      .HALT_DETECT (1'b1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .Address      (Address),
      .Instruction  (Instruction),
      .Ready        (Ready),
      .BranchTaken  (BranchTaken),
      .BranchTarget (BranchTarget),
      .Valid        (Valid),
      .InstrOut     (InstrOut),
      .PCOut        (PCOut),
      .PCPlus4Out   (PCPlus4Out),
      .Halted       (Halted),
      .Fault        (Fault),
      .DeliverCount (DeliverCount)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit bad_addr(input logic [31:0] a);
      return (a % 4 != 0) || ((a / 4) >= MEM_WORDS);
   endfunction

   // One clock of the fetch rules, applied to the inputs currently driven.
   task automatic model_update();
      logic [31:0] word;
      if (reset) begin
         m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h13; m_pcout = 32'h0;
         m_pcp4 = 32'h0; m_halted = 1'b0; m_fault = 1'b0; m_count = 32'h0;
         m_mode = M_RUN;
         return;
      end
      if (m_valid && Ready && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
      if (m_mode == M_RUN) begin
         if (BranchTaken) begin
            m_valid = 1'b0;
            if (bad_addr(BranchTarget)) begin
               m_mode = M_FAULT; m_fault = 1'b1;
            end else begin
               m_pc = BranchTarget;
            end
         end else if ((m_pc / 4) >= MEM_WORDS) begin
            m_mode = M_FAULT; m_fault = 1'b1; m_valid = 1'b0;
         end else if (!m_valid || Ready) begin
            word    = rom_rd(m_pc);
            m_instr = word;
            m_pcout = m_pc;
            m_pcp4  = m_pc + 4;
            m_valid = 1'b1;
            if (word == HALT_INSN) begin
               m_mode = M_HALT; m_halted = 1'b1;
            end else begin
               m_pc = m_pc + 4;
            end
         end
      end else if (m_mode == M_HALT) begin
         if (m_valid && Ready) m_valid = 1'b0;
      end else begin
         m_valid = 1'b0;
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".Address"},  Address,              m_pc);
      check({tag, ".Valid"},    {31'h0, Valid},       {31'h0, m_valid});
      check({tag, ".InstrOut"}, InstrOut,             m_instr);
      check({tag, ".PCOut"},    PCOut,                m_pcout);
      check({tag, ".PCPlus4"},  PCPlus4Out,           m_pcp4);
      check({tag, ".Halted"},   {31'h0, Halted},      {31'h0, m_halted});
      check({tag, ".Fault"},    {31'h0, Fault},       {31'h0, m_fault});
      check({tag, ".Count"},    DeliverCount,         m_count);
   endtask

   // Inputs are driven by the caller between edges; sampling is 1ns after.
   task automatic step(input string tag);
      model_update();
      @(posedge clk);
      #1;
      compare_all(tag);
   endtask

   task automatic drive(input logic rst, input logic rdy, input logic bt, input logic [31:0] tgt);
      reset = rst; Ready = rdy; BranchTaken = bt; BranchTarget = tgt;
   endtask

   initial begin : main
      logic [31:0] w;
      logic [31:0] addr_hold;
      logic [31:0] cnt_hold;

      for (int i = 0; i < MEM_WORDS; i++) begin
         w = $urandom;
         if (w == HALT_INSN) w = 32'h0000_0013;
         rom[i] = w;
      end
      rom[0]  = 32'h0320_0293;
      rom[1]  = 32'h00a0_0313;
      rom[2]  = 32'h0050_2023;
      rom[12] = 32'h0010_0093;
      rom[16] = 32'h0020_0113;
      rom[17] = HALT_INSN;

      // ---------------- reset state ----------------
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      step("rst");
      check("rst_nop", InstrOut, 32'h0000_0013);
      check("rst_valid", {31'h0, Valid}, 32'h0);

      // ---------------- straight-line fetch ----------------
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      step("sl0");
      check("sl0_instr", InstrOut, 32'h0320_0293);
      check("sl0_pc", PCOut, 32'h0);
      check("sl0_pc4", PCPlus4Out, 32'h4);
      step("sl1");
      check("sl1_instr", InstrOut, 32'h00a0_0313);
      check("sl1_pc", PCOut, 32'h4);

      // ---------------- stall ----------------
      Ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step("stall");
         check("stall_addr", Address, 32'h8);
         check("stall_instr", InstrOut, 32'h00a0_0313);
      end
      Ready = 1'b1;
      step("unstall");
      check("unstall_instr", InstrOut, 32'h0050_2023);
      check("unstall_pc", PCOut, 32'h8);
      check("unstall_pc4", PCPlus4Out, 32'hC);
      step("sl3");
      check("sl3_count", DeliverCount, 32'd3);

      // ---------------- redirect with Ready=0 ----------------
      drive(1'b0, 1'b0, 1'b1, 32'h30);
      cnt_hold = DeliverCount;
      step("br0");
      check("br0_valid", {31'h0, Valid}, 32'h0);
      check("br0_addr", Address, 32'h30);
      check("br0_count", DeliverCount, cnt_hold);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      step("br0_fetch");
      check("br0_instr", InstrOut, 32'h0010_0093);
      check("br0_pcout", PCOut, 32'h30);

      // ---------------- redirect with Ready=1 ----------------
      cnt_hold = DeliverCount;
      drive(1'b0, 1'b1, 1'b1, 32'h30);
      step("br1");
      check("br1_count", DeliverCount, cnt_hold + 32'd1);
      check("br1_valid", {31'h0, Valid}, 32'h0);

      // ---------------- halt ----------------
      drive(1'b0, 1'b1, 1'b1, 32'h40);
      step("h_br");
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      step("h0");
      step("h1");
      check("halt_instr", InstrOut, HALT_INSN);
      check("halt_pc", PCOut, 32'h44);
      step("h2");
      check("halt_halted", {31'h0, Halted}, 32'h1);
      check("halt_valid", {31'h0, Valid}, 32'h0);
      drive(1'b0, 1'b1, 1'b1, 32'h0);
      step("h3");
      check("halt_addr", Address, 32'h44);
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      step("h4");

      // ---------------- misaligned redirect fault ----------------
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      step("f_rst");
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      step("f_run");
      addr_hold = Address;
      drive(1'b0, 1'b1, 1'b1, 32'h22);
      step("f_mis");
      check("fmis_fault", {31'h0, Fault}, 32'h1);
      check("fmis_valid", {31'h0, Valid}, 32'h0);
      check("fmis_addr", Address, addr_hold);
      drive(1'b0, 1'b1, 1'b1, 32'h10);
      step("f_mis_hold");
      check("fmis_hold_addr", Address, addr_hold);

      // ---------------- out-of-range redirect fault ----------------
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      step("f2_rst");
      drive(1'b0, 1'b1, 1'b1, 32'h1000);
      step("f_oor");
      check("foor_fault", {31'h0, Fault}, 32'h1);
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      step("f_clr");
      check("fclr_fault", {31'h0, Fault}, 32'h0);
      check("fclr_addr", Address, 32'h0);

      // ---------------- sequential run off the end of the ROM ----------------
      drive(1'b0, 1'b1, 1'b1, 32'hFF8);
      step("end_br");
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) step("end_run");
      check("end_fault", {31'h0, Fault}, 32'h1);
      check("end_addr", Address, 32'h1000);

      // ---------------- reset mid-stream ----------------
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      step("ms_rst0");
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      step("ms0");
      Ready = 1'b0;
      step("ms1");
      reset = 1'b1;
      step("ms_rst");
      check("ms_valid", {31'h0, Valid}, 32'h0);
      check("ms_instr", InstrOut, 32'h0000_0013);
      check("ms_count", DeliverCount, 32'h0);
      check("ms_addr", Address, 32'h0);

      // ---------------- randomized traffic ----------------
      for (int i = 0; i < 6; i++) rom[$urandom_range(MEM_WORDS - 1)] = HALT_INSN;
      for (int c = 0; c < 4000; c++) begin
         logic [31:0] t;
         int          sel;
         reset       = ($urandom_range(99) < 2);
         Ready       = ($urandom_range(3) != 0);
         BranchTaken = ($urandom_range(11) == 0);
         sel = int'($urandom_range(9));
         case (sel)
            0:       t = $urandom;
            1:       t = 32'(($urandom_range(3) + MEM_WORDS - 4) * 4);
            2:       t = {$urandom_range(255), 2'b00} | 32'(1 + $urandom_range(2));
            default: t = 32'($urandom_range(MEM_WORDS - 1) * 4);
         endcase
         BranchTarget = t;
         step("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
